// File: rtl/seq_divider_8b_pkg.sv
// Shared state encoding and iteration constants for the sequential divider.
package seq_divider_8b_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  localparam logic [3:0] DIV_ITER = 4'd8;
  localparam logic [2:0] DIV_LAST = 3'(DIV_ITER - 4'd1);

endpackage

// File: rtl/seq_divider_8b_if.sv
// start/busy/done request bus shared by the ALU's multi-cycle units.
interface seq_divider_8b_if;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider_8b_adder_8b.sv
// 8-bit ripple-carry adder used for the trial subtraction.
// Latency: combinational.
// Backpressure: none.
module adder_8b (
  input  logic [7:0] i0,
  input  logic [7:0] i1,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  always_comb begin
    logic c;
    c   = cin;
    sum = '0;
    for (int i = 0; i < 8; i++) begin
      sum[i] = i0[i] ^ i1[i] ^ c;
      c      = (i0[i] & i1[i]) | (c & (i0[i] ^ i1[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/seq_divider_8b.sv
// Unsigned 8-bit restoring divider, one quotient bit per clock.
// Latency: done 9 cycles after an accepted start (1 cycle on divide-by-zero).
// Backpressure: start is only sampled in IDLE; requests while busy are dropped.
module seq_divider_8b
  import seq_divider_8b_pkg::*;
#(
  parameter int             WIDTH     = 8,
  parameter logic [WIDTH-1:0] DIVZERO_Q = 8'hFF
) (
  input  logic          clk,
  input  logic          reset,
  seq_divider_8b_if.slave bus
);

  div_state_t       state, state_nxt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-2:0] r_r;
  logic [WIDTH-1:0] r_d;
  logic [2:0]       cnt;

  logic [WIDTH-1:0] rs, diff, r_new, q_new;
  logic             no_borrow;
  logic             busy, done;

  // R stays below 2^7 until the last step, so only 7 bits feed the shift.
  assign rs = {r_r, r_q[WIDTH-1]};

  adder_8b u_sub (
    .i0   (rs),
    .i1   (~r_d),
    .cin  (1'b1),
    .sum  (diff),
    .cout (no_borrow)
  );

  assign r_new = no_borrow ? diff : rs;
  assign q_new = {r_q[WIDTH-2:0], no_borrow};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= DIV_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DIV_IDLE: if (bus.start) state_nxt = (bus.divisor == '0) ? DIV_DONE : DIV_CALC;
      DIV_CALC: if (cnt == DIV_LAST) state_nxt = DIV_DONE;
      DIV_DONE: state_nxt = DIV_IDLE;
      default:  state_nxt = DIV_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != DIV_IDLE);
    done = (state == DIV_DONE);
  end

  assign bus.busy = busy;
  assign bus.done = done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q             <= '0;
      r_r             <= '0;
      r_d             <= '0;
      cnt             <= '0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: if (bus.start) begin
          r_q <= bus.dividend;
          r_r <= '0;
          r_d <= bus.divisor;
          cnt <= '0;
          if (bus.divisor == '0) begin
            bus.quotient    <= DIVZERO_Q;
            bus.remainder   <= bus.dividend;
            bus.div_by_zero <= 1'b1;
          end
        end
        DIV_CALC: begin
          r_q <= q_new;
          r_r <= r_new[WIDTH-2:0];
          cnt <= cnt + 3'd1;
          if (cnt == DIV_LAST) begin
            bus.quotient    <= q_new;
            bus.remainder   <= r_new;
            bus.div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_8b.sv
// Directed and swept checks of seq_divider_8b against a cycle-timed result model.
module tb_seq_divider_8b;

  logic clk;
  logic reset;
  seq_divider_8b_if bus ();

  seq_divider_8b dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests_run = 0;
  int tests_failed = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an accepted op is active for m_len cycles; results appear in its last cycle.
  bit         m_active;
  int         m_age, m_len;
  logic [7:0] m_q, m_r, p_q, p_r;
  bit         m_z, p_z;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active <= 1'b0;
      m_age    <= 0;
      m_len    <= 0;
      m_q      <= 8'h00;
      m_r      <= 8'h00;
      m_z      <= 1'b0;
    end else if (m_active) begin
      if (m_age == m_len) m_active <= 1'b0;
      else begin
        m_age <= m_age + 1;
        if (m_age + 1 == m_len) begin
          m_q <= p_q;
          m_r <= p_r;
          m_z <= p_z;
        end
      end
    end else if (bus.start) begin
      m_active <= 1'b1;
      m_age    <= 1;
      if (bus.divisor == 8'd0) begin
        m_len <= 1;
        m_q   <= 8'hFF;
        m_r   <= bus.dividend;
        m_z   <= 1'b1;
      end else begin
        m_len <= 9;
        p_q   <= bus.dividend / bus.divisor;
        p_r   <= bus.dividend % bus.divisor;
        p_z   <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    check("cycle {busy,done,q,r,dbz}",
          {13'd0, bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero},
          {13'd0, m_active, (m_active && m_age == m_len), m_q, m_r, m_z});
  end

  task automatic pulse_start(input logic [7:0] a, input logic [7:0] b);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.dividend = 8'($urandom); bus.divisor = 8'($urandom);
  endtask

  task automatic wait_done(inout int n);
    while (!bus.done && n < 40) begin
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic run_div(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] eq, input logic [7:0] er, input bit ez, input int elat);
    int n;
    pulse_start(a, b);
    n = 1;
    wait_done(n);
    check({name, " latency"}, n, elat);
    check({name, " quotient"}, bus.quotient, eq);
    check({name, " remainder"}, bus.remainder, er);
    check({name, " div_by_zero"}, bus.div_by_zero, ez);
    check({name, " model quotient"}, m_q, eq);
    check({name, " model remainder"}, m_r, er);
    @(posedge clk); #1;
    check({name, " idle after done"}, bus.busy, 1'b0);
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] b);
    int n;
    pulse_start(a, b);
    n = 1;
    wait_done(n);
    check("sweep result", {bus.quotient, bus.remainder}, {a / b, a % b});
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, dcnt, last;
    reset = 1'b1;
    bus.start = 1'b0; bus.dividend = 8'd0; bus.divisor = 8'd0;
    #12;
    check("reset outputs", {bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero}, 19'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    run_div("100/7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 9);
    run_div("255/1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 9);
    run_div("3/10", 8'd3, 8'd10, 8'd0, 8'd3, 1'b0, 9);
    run_div("200/200", 8'd200, 8'd200, 8'd1, 8'd0, 1'b0, 9);
    run_div("5/0", 8'd5, 8'd0, 8'hFF, 8'd5, 1'b1, 1);
    run_div("17/4", 8'd17, 8'd4, 8'd4, 8'd1, 1'b0, 9);
    run_div("9/3", 8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 9);
    run_div("0/0", 8'd0, 8'd0, 8'hFF, 8'd0, 1'b1, 1);
    run_div("128/255", 8'd128, 8'd255, 8'd0, 8'd128, 1'b0, 9);

    // Start re-pulsed mid-run with different operands must be ignored.
    pulse_start(8'd250, 8'd150);
    n = 1;
    while (n < 4) begin @(posedge clk); #1; n++; end
    bus.start = 1'b1; bus.dividend = 8'd9; bus.divisor = 8'd3;
    @(posedge clk); #1; n++;
    bus.start = 1'b0;
    wait_done(n);
    check("repulse latency", n, 9);
    check("repulse result", {bus.quotient, bus.remainder}, {8'd1, 8'd100});
    @(posedge clk); #1;

    // Start held high: second acceptance on the first IDLE cycle after DONE.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.dividend = 8'd9; bus.divisor = 8'd3;
    @(posedge clk); #1;
    dcnt = 0; last = 0;
    for (int i = 1; i <= 19; i++) begin
      if (bus.done) begin dcnt++; last = i; end
      if (i < 19) begin @(posedge clk); #1; end
    end
    bus.start = 1'b0;
    check("held start done count", dcnt, 2);
    check("held start second done cycle", last, 19);
    @(posedge clk); #1;

    // Reset in cycle 5 aborts at once with no done pulse.
    pulse_start(8'd100, 8'd7);
    n = 1;
    while (n < 5) begin @(posedge clk); #1; n++; end
    reset = 1'b1;
    #1;
    check("reset mid-calc outputs", {bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero}, 19'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.done) dcnt++;
    end
    check("no done after reset", dcnt, 0);
    run_div("20/6", 8'd20, 8'd6, 8'd3, 8'd2, 1'b0, 9);

    for (int d = 1; d < 256; d++) do_op(8'd255, 8'(d));
    for (int a = 0; a < 256; a++) do_op(8'(a), 8'd7);
    for (int i = 0; i < 2500; i++) begin
      logic [7:0] a, b;
      a = 8'($urandom);
      b = 8'($urandom_range(255, 1));
      do_op(a, b);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
